video_pll_ctrl: RTL and testbench

- Reset/lock sequencer for the video PLL. Runs on the free-running 50 MHz board clock, not on a PLL output.
- Drives the PLL reset, synchronises and qualifies the PLL lock, and releases the video-domain reset only after lock has been stable for a set time.
- Retries on lock timeout, re-sequences on lock loss or software request, and reports status to the control/debug logic.

---
 rtl/video_pll_ctrl.sv | 144 ++++++++++++++
 tb/tb_video_pll_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pll_ctrl.sv
// Reset/lock sequencer for the video PLL, clocked from the free-running board clock.
// Pulses the PLL reset, qualifies a synchronised lock and gates the video-domain reset.
module video_pll_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RETRY_MAX    = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       video_rst_n,
  output logic       pll_ready,
  output logic       pll_fail,
  output logic [2:0] ctrl_state,
  output logic [7:0] lock_lost_cnt
);

  localparam int MAX_AB   = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int MAX_TERM = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CNT_W    = (MAX_TERM > 1) ? $clog2(MAX_TERM) : 1;
  localparam int RTY_W    = $clog2(RETRY_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_LIM  = RTY_W'(RETRY_MAX);

  typedef enum logic [2:0] {
    ST_PRST   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RTY_W-1:0] retry_cnt, retry_nxt, retry_inc;
  logic [7:0]       lost_nxt;
  logic             lock_p0, lock_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign retry_inc  = retry_cnt + RTY_W'(1);
  assign ctrl_state = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    lost_nxt  = lock_lost_cnt;
    if (relock_req) begin
      // a lock loss coinciding with a relock request is still counted
      state_nxt = ST_PRST;
      cnt_nxt   = '0;
      retry_nxt = '0;
      if (state == ST_RUN && !lock_s) lost_nxt = sat_inc8(lock_lost_cnt);
    end else begin
      case (state)
        ST_PRST: begin
          if (cnt == RST_LAST) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (lock_s) begin
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
          end else if (cnt == TMO_LAST) begin
            cnt_nxt   = '0;
            retry_nxt = retry_inc;
            state_nxt = (retry_inc == RTY_LIM) ? ST_FAIL : ST_PRST;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          // a drop on the terminal cycle still falls back to WAIT
          if (!lock_s) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = '0;
          end else if (cnt == STB_LAST) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_nxt = ST_PRST;
            cnt_nxt   = '0;
            lost_nxt  = sat_inc8(lock_lost_cnt);
          end
        end
        ST_FAIL: begin
          state_nxt = ST_FAIL;
        end
        default: begin
          state_nxt = ST_PRST;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      endcase
    end
  end

  // lock synchroniser stage and state/output registers; outputs decode the next state
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      lock_p0       <= 1'b0;
      lock_s        <= 1'b0;
      state         <= ST_PRST;
      cnt           <= '0;
      retry_cnt     <= '0;
      lock_lost_cnt <= 8'd0;
      pll_rst       <= 1'b1;
      video_rst_n   <= 1'b0;
      pll_ready     <= 1'b0;
      pll_fail      <= 1'b0;
    end else begin
      lock_p0       <= pll_lock;
      lock_s        <= lock_p0;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      retry_cnt     <= retry_nxt;
      lock_lost_cnt <= lost_nxt;
      pll_rst       <= (state_nxt == ST_PRST);
      video_rst_n   <= (state_nxt == ST_RUN);
      pll_ready     <= (state_nxt == ST_RUN);
      pll_fail      <= (state_nxt == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_video_pll_ctrl.sv
// Bench for video_pll_ctrl: directed table, corner-case sequences and random stimulus
// checked every cycle against a timestamp-based reference model.
module tb_video_pll_ctrl;

  localparam int RC = 4;
  localparam int LS = 8;
  localparam int LT = 32;
  localparam int RM = 2;

  localparam int P_PRST   = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAIL   = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, video_rst_n, pll_ready, pll_fail;
  logic [2:0] ctrl_state;
  logic [7:0] lock_lost_cnt;

  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  video_pll_ctrl #(
    .RST_CYCLES  (RC),
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(LT),
    .RETRY_MAX   (RM)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .pll_lock     (pll_lock),
    .relock_req   (relock_req),
    .pll_rst      (pll_rst),
    .video_rst_n  (video_rst_n),
    .pll_ready    (pll_ready),
    .pll_fail     (pll_fail),
    .ctrl_state   (ctrl_state),
    .lock_lost_cnt(lock_lost_cnt)
  );

  // Reference model: phase plus the edge index at which the phase was entered.
  int         m_phase = P_PRST;
  int         m_t0 = 0;
  int         m_lost = 0;
  int         m_retry = 0;
  int         edge_n = 0;
  logic [1:0] lock_hist = 2'b00;

  function automatic void enter(input int p);
    m_phase = p;
    m_t0    = edge_n;
  endfunction

  task automatic model_edge();
    logic ls;
    int   el;
    edge_n++;
    ls = lock_hist[1];
    el = edge_n - m_t0;
    if (!sys_rst_n) begin
      enter(P_PRST);
      m_lost    = 0;
      m_retry   = 0;
      lock_hist = 2'b00;
    end else begin
      if (relock_req) begin
        if (m_phase == P_RUN && !ls) m_lost = (m_lost < 255) ? m_lost + 1 : 255;
        m_retry = 0;
        enter(P_PRST);
      end else begin
        case (m_phase)
          P_PRST:   if (el == RC) enter(P_WAIT);
          P_WAIT: begin
            if (ls) enter(P_STABLE);
            else if (el == LT) begin
              m_retry++;
              enter((m_retry == RM) ? P_FAIL : P_PRST);
            end
          end
          P_STABLE: begin
            if (!ls) enter(P_WAIT);
            else if (el == LS) begin
              m_retry = 0;
              enter(P_RUN);
            end
          end
          P_RUN: begin
            if (!ls) begin
              m_lost = (m_lost < 255) ? m_lost + 1 : 255;
              enter(P_PRST);
            end
          end
          default: ;
        endcase
      end
      lock_hist = {lock_hist[0], pll_lock};
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    logic [14:0] got, exp;
    @(posedge sys_clk);
    model_edge();
    #1;
    got = {pll_rst, video_rst_n, pll_ready, pll_fail, ctrl_state, lock_lost_cnt};
    exp = {m_phase == P_PRST, m_phase == P_RUN, m_phase == P_RUN, m_phase == P_FAIL,
           3'(m_phase), 8'(m_lost)};
    check($sformatf("model@%0d", edge_n), 32'(got), 32'(exp));
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc, output int n);
    n = 0;
    while (ctrl_state !== s && n < maxc) begin
      tick();
      n++;
    end
    check($sformatf("reach_state%0d", s), 32'(ctrl_state), 32'(s));
  endtask

  typedef struct {
    int rst_n, lock, relock, n;
    int st, prst, vrst_n, fail, lost;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int rst_n, lock, relock, n, st, prst, vrst_n, fail, lost);
    vec_t v;
    v.rst_n = rst_n; v.lock = lock; v.relock = relock; v.n = n;
    v.st = st; v.prst = prst; v.vrst_n = vrst_n; v.fail = fail; v.lost = lost;
    tbl.push_back(v);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int mode;
    // rst_n lock relock cycles | state pll_rst video_rst_n pll_fail lost
    add(0,0,0, 2,  0,1,0,0,0);
    add(1,0,0, 3,  0,1,0,0,0);
    add(1,0,0, 1,  1,0,0,0,0);
    add(1,0,0, 9,  1,0,0,0,0);
    add(1,1,0, 2,  1,0,0,0,0);
    add(1,1,0, 1,  2,0,0,0,0);
    add(1,1,0, 7,  2,0,0,0,0);
    add(1,1,0, 1,  3,0,1,0,0);
    add(1,0,0, 2,  3,0,1,0,0);
    add(1,0,0, 1,  0,1,0,0,1);
    add(1,0,0, 3,  0,1,0,0,1);
    add(1,0,0, 1,  1,0,0,0,1);
    add(1,0,1, 1,  0,1,0,0,1);
    add(1,0,0, 4,  1,0,0,0,1);
    add(1,0,0, 31, 1,0,0,0,1);
    add(1,0,0, 1,  0,1,0,0,1);
    add(1,0,0, 3,  0,1,0,0,1);
    add(1,0,0, 1,  1,0,0,0,1);
    add(1,0,0, 31, 1,0,0,0,1);
    add(1,0,0, 1,  4,0,0,1,1);
    add(1,0,0, 50, 4,0,0,1,1);
    add(1,0,1, 1,  0,1,0,0,1);
    add(1,0,0, 4,  1,0,0,0,1);
    add(1,0,0, 32, 0,1,0,0,1);
    add(1,0,0, 4,  1,0,0,0,1);
    add(0,0,0, 1,  0,1,0,0,0);
    add(1,0,0, 3,  0,1,0,0,0);
    add(1,0,0, 1,  1,0,0,0,0);

    foreach (tbl[i]) begin
      sys_rst_n  = tbl[i].rst_n[0];
      pll_lock   = tbl[i].lock[0];
      relock_req = tbl[i].relock[0];
      for (int k = 0; k < tbl[i].n; k++) tick();
      check($sformatf("tbl%0d_state", i), 32'(ctrl_state), 32'(tbl[i].st));
      check($sformatf("tbl%0d_pll_rst", i), 32'(pll_rst), 32'(tbl[i].prst));
      check($sformatf("tbl%0d_video_rst_n", i), 32'(video_rst_n), 32'(tbl[i].vrst_n));
      check($sformatf("tbl%0d_pll_fail", i), 32'(pll_fail), 32'(tbl[i].fail));
      check($sformatf("tbl%0d_lost", i), 32'(lock_lost_cnt), 32'(tbl[i].lost));
    end
    relock_req = 1'b0;
    sys_rst_n  = 1'b1;

    // lock chatter: lock_s low for one cycle at stable count 5
    pll_lock = 1'b1;
    wait_state(3'd2, 60, n);
    repeat (3) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    repeat (2) tick();
    check("chatter_back_to_wait", 32'(ctrl_state), 32'd1);
    check("chatter_no_prst", 32'(pll_rst), 32'd0);
    wait_state(3'd2, 10, n);
    wait_state(3'd3, 20, n);
    check("chatter_fresh_stable_len", 32'(n), 32'(LS));

    // lock loss in RUN: video reset falls three edges after the raw lock drops
    pll_lock = 1'b0;
    repeat (2) tick();
    check("loss_vrst_still_high", 32'(video_rst_n), 32'd1);
    tick();
    check("loss_vrst_low", 32'(video_rst_n), 32'd0);
    check("loss_cnt_one", 32'(lock_lost_cnt), 32'd1);
    n = 0;
    while (pll_rst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("loss_prst_pulse_len", 32'(n), 32'(RC));

    // lock drop seen on the STABLE terminal-count cycle
    pll_lock = 1'b1;
    wait_state(3'd2, 60, n);
    repeat (5) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    repeat (2) tick();
    check("term_drop_to_wait", 32'(ctrl_state), 32'd1);
    wait_state(3'd3, 30, n);

    // relock pulse in RUN
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("relock_run_state", 32'(ctrl_state), 32'd0);
    check("relock_run_vrst", 32'(video_rst_n), 32'd0);
    check("relock_run_lost_kept", 32'(lock_lost_cnt), 32'd1);

    // lock loss and relock on the same cycle in RUN
    wait_state(3'd3, 40, n);
    pll_lock = 1'b0;
    repeat (2) tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("loss_relock_state", 32'(ctrl_state), 32'd0);
    check("loss_relock_lost", 32'(lock_lost_cnt), 32'd2);

    // saturation of the loss counter
    for (int i = 0; i < 256; i++) begin
      pll_lock = 1'b1;
      wait_state(3'd3, 60, n);
      pll_lock = 1'b0;
      wait_state(3'd0, 10, n);
    end
    check("lost_saturated", 32'(lock_lost_cnt), 32'd255);

    // randomized stimulus against the model
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0:       if ($urandom_range(0, 23) == 0) pll_lock = ~pll_lock;
        1:       if ($urandom_range(0, 199) == 0) pll_lock = ~pll_lock;
        default: pll_lock = ($urandom_range(0, 99) != 0);
      endcase
      relock_req = ($urandom_range(0, 79) == 0);
      sys_rst_n  = ($urandom_range(0, 699) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
